control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port run  input  1  permits a new instruction fetch when high.
REQ-004 SHALL have port instr  input  8  RAM read data; [7:4] opcode, [3:0] operand.
REQ-005 SHALL have port ram_enable  output  1  RAM access strobe.
REQ-006 SHALL have port we  output  1  RAM write enable; valid only with ram_enable.
REQ-007 SHALL have port gp_read  output  1  register file drives data bus.
REQ-008 SHALL have port gp_write  output  1  register file captures data bus.
REQ-009 SHALL have port gp_sel  output  4  register index, equal to the captured operand.
REQ-010 SHALL have port grab_ula  output  1  ALU result captured into its buffer.
REQ-011 SHALL have port latch_ula  output  1  ALU buffer driven onto data bus.
REQ-012 SHALL have port ula_operation  output  4  ALU operation code.
REQ-013 SHALL have port pc_increment  output  1  PC advances by one.
REQ-014 SHALL have port pc_count  output  1  PC loads the jump target from operand.
REQ-015 SHALL have port operand  output  4  captured instr[3:0].
REQ-016 SHALL have port halted  output  1  high while in HALT.
REQ-017 SHALL have port illegal  output  1  sticky illegal-opcode flag.

Function
REQ-018 SHALL implement states IDLE, FETCH, DECODE, EXEC, WB, HALT; all strobes are Moore outputs of one cycle width.
REQ-019 IDLE: go to FETCH when run=1, else remain; no strobes.
REQ-020 FETCH: ram_enable=1, we=0; next DECODE (RAM read latency of one cycle).
REQ-021 DECODE: capture instr into the instruction register; pc_increment=1; next EXEC.
REQ-022 Opcode 0x0 NOP: EXEC has no strobes; next IDLE.
REQ-023 Opcode 0x1 READ: EXEC gp_read=1; next IDLE.
REQ-024 Opcode 0x2 WRITE: EXEC gp_write=1; next IDLE.
REQ-025 Opcode 0x3 JMP: EXEC pc_count=1; next IDLE; pc_count and pc_increment are never high in the same cycle.
REQ-026 Opcode 0x4 STORE: EXEC ram_enable=1, we=1; next IDLE.
REQ-027 Opcode 0x7 HALT: EXEC has no strobes; next HALT; HALT is exited only by reset and ignores run.
REQ-028 Opcodes 0x8-0xF ALU: ula_operation={1'b0,opcode[2:0]} held through EXEC and WB; EXEC grab_ula=1; WB latch_ula=1 and gp_write=1; next IDLE.
REQ-029 ula_operation SHALL be 4'h0 outside EXEC and WB.
REQ-030 gp_sel and operand SHALL equal the instruction register's [3:0] in every cycle.
REQ-031 latch_ula and gp_read SHALL never be high in the same cycle (single bus driver).
REQ-032 Instruction latency from FETCH to return to IDLE: 3 cycles for non-ALU opcodes, 4 cycles for ALU opcodes; run=1 held gives back-to-back instructions with one IDLE cycle between them.
REQ-033 Opcodes 0x5 and 0x6 are illegal; handling is per REQ-037/REQ-038.
REQ-034 run deasserted mid-instruction SHALL NOT abort the instruction.

Reset
REQ-035 reset=1 at a clock edge SHALL force IDLE, clear the instruction register to 0x00, and clear illegal, in any state including mid-instruction and HALT.
REQ-036 During and after reset, all outputs SHALL be 0 until the next FETCH.

Configuration
REQ-037 With CONTROL_UNIT_ILLEGAL_TRAP_EN defined, an illegal opcode in EXEC SHALL set illegal=1 (sticky until reset) and go to HALT.
REQ-038 Without CONTROL_UNIT_ILLEGAL_TRAP_EN, an illegal opcode SHALL execute as NOP, and illegal SHALL be tied to 0.

Verification
REQ-039 Reset, run=1, instr=0x8A -> FETCH, DECODE(pc_increment), EXEC(grab_ula, ula_operation=0x0), WB(latch_ula, gp_write, gp_sel=0xA), then IDLE.
REQ-040 instr=0x35 -> EXEC pc_count=1, operand=0x5, and pc_increment=0 in that cycle.
REQ-041 instr=0x4C -> EXEC ram_enable=1, we=1; FETCH shows ram_enable=1, we=0.
REQ-042 instr=0x70 -> halted=1 persists for 20 cycles with run=1; reset then gives halted=0 and IDLE.
REQ-043 instr=0x50 -> with macro: illegal=1, halted=1; without macro: NOP timing, illegal=0.
REQ-044 reset asserted in WB of 0x9F -> next cycle all outputs 0, state IDLE, no gp_write.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC(/WB) driving RAM, register file, ALU and PC strobes.
// Optional illegal-opcode trap (opcodes 0x5/0x6 -> HALT) enabled by CONTROL_UNIT_ILLEGAL_TRAP_EN.
module control_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] instr,
  output logic       ram_enable,
  output logic       we,
  output logic       gp_read,
  output logic       gp_write,
  output logic [3:0] gp_sel,
  output logic       grab_ula,
  output logic       latch_ula,
  output logic [3:0] ula_operation,
  output logic       pc_increment,
  output logic       pc_count,
  output logic [3:0] operand,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] opcode;
  logic       trap_set;

  assign opcode  = ir_q[7:4];
  assign gp_sel  = ir_q[3:0];
  assign operand = ir_q[3:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (trap_set) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    trap_set      = 1'b0;
    ram_enable    = 1'b0;
    we            = 1'b0;
    gp_read       = 1'b0;
    gp_write      = 1'b0;
    grab_ula      = 1'b0;
    latch_ula     = 1'b0;
    ula_operation = 4'h0;
    pc_increment  = 1'b0;
    pc_count      = 1'b0;
    halted        = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        ram_enable = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        // RAM data arrives one cycle after the FETCH strobe
        ir_d         = instr;
        pc_increment = 1'b1;
        state_d      = EXEC;
      end
      EXEC: begin
        state_d = IDLE;
        if (opcode[3]) begin
          grab_ula      = 1'b1;
          ula_operation = {1'b0, opcode[2:0]};
          state_d       = WB;
        end else begin
          case (opcode)
            4'h1: gp_read  = 1'b1;
            4'h2: gp_write = 1'b1;
            4'h3: pc_count = 1'b1;
            4'h4: begin
              ram_enable = 1'b1;
              we         = 1'b1;
            end
            4'h7: state_d = HALT;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
            4'h5, 4'h6: begin
              trap_set = 1'b1;
              state_d  = HALT;
            end
`endif
            default: ;
          endcase
        end
      end
      WB: begin
        latch_ula     = 1'b1;
        gp_write      = 1'b1;
        ula_operation = {1'b0, opcode[2:0]};
        state_d       = IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
